// File: rtl/riscv_pkg.sv
// Shared RV64 fetch constants: data/instruction widths, the bubble encoding and
// the boot image used to initialise instruction memory.
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned IMEM_INIT_WORDS = 16;

    // Boot image, one 32-bit instruction per word address.
    localparam logic [ILEN-1:0] IMEM_INIT [IMEM_INIT_WORDS] = '{
        32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4020_8233,
        32'h0031_0293, 32'h0042_A023, 32'h0002_A303, 32'h0062_8463,
        32'h1234_5008, 32'h1234_5009, 32'h1234_500A, 32'h1234_500B,
        32'h1234_500C, 32'h1234_500D, 32'h1234_500E, 32'hDEAD_BEEF
    };

endpackage

// File: rtl/instruction_memory.sv
// Byte-addressed little-endian ROM with a combinational 32-bit word read;
// addresses past the end of memory return the bubble instruction.
module instruction_memory
    import riscv_pkg::*;
#(
    parameter int unsigned     IMEM_BYTES = 64,
    parameter logic [ILEN-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic [XLEN-1:0] addr,
    output logic [ILEN-1:0] instr_c
);

    localparam int unsigned AW = $clog2(IMEM_BYTES);

    logic [7:0]    mem [IMEM_BYTES];
    logic [AW-3:0] widx;
    logic          in_range;

    // Spread the word table into bytes, LSB at the lowest address.
    for (genvar i = 0; i < int'(IMEM_BYTES); i++) begin : g_bytes
        if ((i / 4) < int'(IMEM_INIT_WORDS)) begin : g_init
            assign mem[i] = IMEM_INIT[i / 4][8 * (i % 4) +: 8];
        end else begin : g_zero
            assign mem[i] = 8'h00;
        end
    end

    assign widx     = addr[AW-1:2];
    assign in_range = addr < XLEN'(IMEM_BYTES);

    always_comb begin
        instr_c = NOP_INSTR;
        if (in_range) begin
            instr_c = {mem[{widx, 2'd3}], mem[{widx, 2'd2}],
                       mem[{widx, 2'd1}], mem[{widx, 2'd0}]};
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, IF/ID pipeline register and a saturating count of
// valid fetches; redirect beats stall, stall beats sequential fetch.
module instruction_fetch_stage
    import riscv_pkg::*;
#(
    parameter int unsigned     IMEM_BYTES = 64,
    parameter logic [ILEN-1:0] NOP_INSTR  = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] IFID_PC,
    output logic [ILEN-1:0] IFID_Instruction,
    output logic            IFID_valid,
    output logic [31:0]     fetch_count
);

    logic [ILEN-1:0] imem_instr;

    instruction_memory #(
        .IMEM_BYTES (IMEM_BYTES),
        .NOP_INSTR  (NOP_INSTR)
    ) u_imem (
        .addr    (PC_out),
        .instr_c (imem_instr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_out           <= '0;
            IFID_PC          <= '0;
            IFID_Instruction <= NOP_INSTR;
            IFID_valid       <= 1'b0;
            fetch_count      <= '0;
        end else if (branch_taken) begin
            // Redirect flushes IF/ID with a bubble and realigns the target.
            PC_out           <= branch_target & ~XLEN'(3);
            IFID_PC          <= '0;
            IFID_Instruction <= NOP_INSTR;
            IFID_valid       <= 1'b0;
        end else if (!stall) begin
            PC_out           <= PC_out + XLEN'(4);
            IFID_PC          <= PC_out;
            IFID_Instruction <= imem_instr;
            IFID_valid       <= 1'b1;
            if (fetch_count != 32'hFFFF_FFFF) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
